// File: rtl/fft_bfly_scheduler_if.sv
// ----------------------------------------------------------------------------
// fft_bfly_scheduler_if
//
// Groups the control/bus signals of the radix-2 DIT FFT butterfly scheduler.
//
// Parameters
//   LOG2N  log2 of FFT size (address width of the sample RAM)
//   TW_AW  twiddle ROM address width
//
// Signals
//   start      begin a transform (only honoured while idle)
//   hold       datapath backpressure, freezes butterfly issue
//   rd_en      butterfly issue strobe
//   rd_addr_a  upper operand read address
//   rd_addr_b  lower operand read address
//   tw_addr    twiddle ROM address
//   tw_valid   rd_en delayed one cycle (aligned with ROM output)
//   wr_en      rd_en delayed by the butterfly latency
//   wr_addr_a  rd_addr_a delayed by the butterfly latency
//   wr_addr_b  rd_addr_b delayed by the butterfly latency
//   stage      current stage index
//   busy       transform in progress
//   done       single-cycle completion pulse
//   cycle_cnt  busy-cycle counter     (only with SCHED_PERF_CNT_EN)
//   hold_cnt   held-issue-cycle count (only with SCHED_PERF_CNT_EN)
//
// Modports
//   master  scheduler side (drives issue/write-back/status)
//   slave   controller/datapath side
//
// Optional feature macro: SCHED_PERF_CNT_EN
// ----------------------------------------------------------------------------
interface fft_bfly_scheduler_if #(
   parameter int LOG2N = 4,
   parameter int TW_AW = 5
);
   localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

   logic             start;
   logic             hold;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [TW_AW-1:0] tw_addr;
   logic             tw_valid;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;
   logic [SW-1:0]    stage;
   logic             busy;
   logic             done;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0]      cycle_cnt;
   logic [15:0]      hold_cnt;

   modport master (
      input  start, hold,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_valid,
             wr_en, wr_addr_a, wr_addr_b, stage, busy, done,
             cycle_cnt, hold_cnt
   );

   modport slave (
      output start, hold,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_valid,
             wr_en, wr_addr_a, wr_addr_b, stage, busy, done,
             cycle_cnt, hold_cnt
   );
`else
   modport master (
      input  start, hold,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_valid,
             wr_en, wr_addr_a, wr_addr_b, stage, busy, done
   );

   modport slave (
      output start, hold,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_valid,
             wr_en, wr_addr_a, wr_addr_b, stage, busy, done
   );
`endif

endinterface

// File: rtl/fft_bfly_scheduler.sv
// ----------------------------------------------------------------------------
// fft_bfly_scheduler
//
// Sequences an in-place radix-2 DIT FFT over a 2^LOG2N-point working memory.
// One butterfly is issued per cycle (operand read addresses + twiddle ROM
// address); the matching write-back addresses come out BFLY_LAT cycles later.
// Between stages the issue is stalled until every in-flight butterfly of the
// stage has been written back, so the next stage never reads stale data.
//
// Parameters
//   LOG2N     log2 of FFT size N (N/2 butterflies per stage, LOG2N stages),
//             at least 2
//   BFLY_LAT  cycles from rd_en to butterfly result (ROM + datapath), >= 1
//   TW_AW     twiddle ROM address width, >= ceil(log2(LOG2N)) + LOG2N - 1
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset (aborts any transform)
//   bus   fft_bfly_scheduler_if.master: start/hold in, issue, write-back
//         and status out (see the interface file for the signal list)
//
// Optional feature macro: SCHED_PERF_CNT_EN
//   Adds 16-bit saturating cycle_cnt (busy cycles) and hold_cnt (held ISSUE
//   cycles); both clear on an accepted start.
// ----------------------------------------------------------------------------
module fft_bfly_scheduler #(
   parameter int LOG2N    = 4,
   parameter int BFLY_LAT = 3,
   parameter int TW_AW    = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   fft_bfly_scheduler_if.master   bus
);

   localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   // In-flight count never exceeds BFLY_LAT; one spare value of headroom.
   localparam int CW = $clog2(BFLY_LAT + 2);

   localparam logic [LOG2N-1:0] KLAST = LOG2N'((1 << (LOG2N - 1)) - 1);
   localparam logic [SW-1:0]    SLAST = SW'(LOG2N - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [LOG2N-1:0] k;
   logic [LOG2N-1:0] k_n;
   logic [SW-1:0]    s;
   logic [SW-1:0]    s_n;
   logic [CW-1:0]    infl;
   logic             issue;
   logic             busy;
   logic             drain_empty;

   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] pos;
   logic [LOG2N-1:0] grp;
   logic [LOG2N-1:0] addr_a;
   logic [LOG2N-1:0] addr_b;
   logic [TW_AW-1:0] tw;

   logic             en_pipe [BFLY_LAT];
   logic [LOG2N-1:0] a_pipe  [BFLY_LAT];
   logic [LOG2N-1:0] b_pipe  [BFLY_LAT];
   logic             tw_v;
   logic             wr_en;

   // -------------------------------------------------------------------------
   // Butterfly address generation for stage s, butterfly k.
   // Shifting grp by s and then by 1 avoids s+1 overflowing the SW-bit stage
   // index in the last stage.
   // -------------------------------------------------------------------------
   always_comb begin
      span   = LOG2N'(1) << s;
      pos    = k & (span - LOG2N'(1));
      grp    = k >> s;
      addr_a = ((grp << s) << 1) | pos;
      addr_b = addr_a + span;
      // Per-stage ROM layout: stage s occupies entries s*(N/2) .. s*(N/2)+N/2-1.
      tw     = (TW_AW'(s) << (LOG2N - 1)) + TW_AW'(k);
   end

   // The stage is drained once the only remaining butterfly (if any) is the
   // one being written back this cycle; no issue happens in DRAIN, so the
   // count can be tested without looking at rd_en.
   assign drain_empty = (infl == CW'(wr_en));

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         s     <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
         s     <= s_n;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and issue strobe
   // -------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      k_n     = k;
      s_n     = s;
      issue   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = ISSUE;
               k_n     = '0;
               s_n     = '0;
            end
         end
         ISSUE: begin
            if (!bus.hold) begin
               issue = 1'b1;
               if (k == KLAST) begin
                  state_n = DRAIN;
               end else begin
                  k_n = k + LOG2N'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               if (s == SLAST) begin
                  state_n = FIN;
               end else begin
                  s_n     = s + SW'(1);
                  k_n     = '0;
                  state_n = ISSUE;
               end
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state == ISSUE) || (state == DRAIN);

   // -------------------------------------------------------------------------
   // In-flight butterfly count: +1 on issue, -1 on write-back.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         infl <= '0;
      end else begin
         infl <= infl + CW'(issue) - CW'(wr_en);
      end
   end

   // -------------------------------------------------------------------------
   // Write-back delay lines (BFLY_LAT deep) and twiddle-valid delay (1 deep)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BFLY_LAT; i++) begin
            en_pipe[i] <= 1'b0;
            a_pipe[i]  <= '0;
            b_pipe[i]  <= '0;
         end
         tw_v <= 1'b0;
      end else begin
         en_pipe[0] <= issue;
         a_pipe[0]  <= bus.rd_addr_a;
         b_pipe[0]  <= bus.rd_addr_b;
         for (int unsigned i = 1; i < BFLY_LAT; i++) begin
            en_pipe[i] <= en_pipe[i-1];
            a_pipe[i]  <= a_pipe[i-1];
            b_pipe[i]  <= b_pipe[i-1];
         end
         tw_v <= issue;
      end
   end

   assign wr_en = en_pipe[BFLY_LAT-1];

   // -------------------------------------------------------------------------
   // Outputs. Read/twiddle addresses are forced to zero outside ISSUE so that
   // everything reads 0 after reset; during hold they stay on the frozen k.
   // -------------------------------------------------------------------------
   assign bus.rd_en     = issue;
   assign bus.rd_addr_a = (state == ISSUE) ? addr_a : '0;
   assign bus.rd_addr_b = (state == ISSUE) ? addr_b : '0;
   assign bus.tw_addr   = (state == ISSUE) ? tw : '0;
   assign bus.tw_valid  = tw_v;
   assign bus.wr_en     = wr_en;
   assign bus.wr_addr_a = a_pipe[BFLY_LAT-1];
   assign bus.wr_addr_b = b_pipe[BFLY_LAT-1];
   assign bus.stage     = s;
   assign bus.busy      = busy;
   assign bus.done      = (state == FIN);

`ifdef SCHED_PERF_CNT_EN
   // -------------------------------------------------------------------------
   // Saturating performance counters; they keep their value after done so
   // software can read them back between transforms.
   // -------------------------------------------------------------------------
   logic [15:0] cycle_cnt;
   logic [15:0] hold_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         hold_cnt  <= '0;
      end else if (state == IDLE && bus.start) begin
         cycle_cnt <= '0;
         hold_cnt  <= '0;
      end else begin
         if (busy && cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 16'd1;
         end
         if (state == ISSUE && bus.hold && hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 16'd1;
         end
      end
   end

   assign bus.cycle_cnt = cycle_cnt;
   assign bus.hold_cnt  = hold_cnt;
`else
`endif

endmodule
